mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto one memory port, one transaction in flight.
// Optional watchdog: define ARB_TIMEOUT_EN to abort stuck transactions with bus_err.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ok,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ok,
    output logic        mem_req,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        cpu_stall,
    output logic        bus_err
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_gnt_data;
    logic             r_mem_req;
    logic [3:0]       r_mem_wen;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [31:0]      r_inst_rdata;
    logic [31:0]      r_data_rdata;
    logic             r_inst_ok;
    logic             r_data_ok;

    logic w_any_req;
    logic w_starved;
    logic w_grant_data;
    logic w_timeout;

    assign w_any_req    = inst_req | data_req;
    assign w_starved    = inst_req && (r_starve_cnt == STARVE_MAX);
    assign w_grant_data = data_req && !w_starved;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_wait_cnt;
    logic       r_bus_err;

    // Counter restarts whenever a new wait phase (ADDR or DATA) begins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == IDLE || r_state == RESP) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == ADDR && mem_addr_ok) begin
            r_wait_cnt <= 8'd0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    assign w_timeout = ((r_state == ADDR) || (r_state == DATA)) && (r_wait_cnt == 8'hFF);
    assign bus_err   = r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_gnt_data   <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_wen    <= 4'd0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_inst_rdata <= 32'd0;
            r_data_rdata <= 32'd0;
            r_inst_ok    <= 1'b0;
            r_data_ok    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_bus_err    <= 1'b0;
`endif
        end else begin
            r_inst_ok <= 1'b0;
            r_data_ok <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_bus_err <= 1'b0;
`endif
            if (w_timeout) begin
                // Abort: complete toward the granted side without touching rdata.
                r_state   <= RESP;
                r_mem_req <= 1'b0;
                r_inst_ok <= !r_gnt_data;
                r_data_ok <= r_gnt_data;
`ifdef ARB_TIMEOUT_EN
                r_bus_err <= 1'b1;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_any_req) begin
                            r_state    <= ADDR;
                            r_mem_req  <= 1'b1;
                            r_gnt_data <= w_grant_data;
                            if (w_grant_data) begin
                                r_mem_addr  <= data_addr;
                                r_mem_wen   <= data_wen;
                                r_mem_wdata <= data_wdata;
                                if (inst_req && (r_starve_cnt != STARVE_MAX)) begin
                                    r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                                end
                            end else begin
                                r_mem_addr   <= inst_addr;
                                r_mem_wen    <= 4'd0;
                                r_mem_wdata  <= 32'd0;
                                r_starve_cnt <= '0;
                            end
                        end
                    end
                    ADDR: begin
                        if (mem_addr_ok) begin
                            r_state   <= DATA;
                            r_mem_req <= 1'b0;
                        end
                    end
                    DATA: begin
                        // Stores complete with an ok pulse but never overwrite load data.
                        if (mem_data_ok) begin
                            r_state <= RESP;
                            if (r_gnt_data) begin
                                r_data_ok <= 1'b1;
                                if (r_mem_wen == 4'd0) begin
                                    r_data_rdata <= mem_rdata;
                                end
                            end else begin
                                r_inst_ok    <= 1'b1;
                                r_inst_rdata <= mem_rdata;
                            end
                        end
                    end
                    RESP: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_wen    = r_mem_wen;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign inst_rdata = r_inst_rdata;
    assign data_rdata = r_data_rdata;
    assign inst_ok    = r_inst_ok;
    assign data_ok    = r_data_ok;

    assign cpu_stall = (inst_req & ~inst_ok) | (data_req & ~data_ok);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// hand-written sequences for starvation, wrong-state acks, reset and timeout.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ok;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ok;
    logic        mem_req;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        cpu_stall;
    logic        bus_err;

    int nAssert = 0;
    int nFail   = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .inst_ok    (inst_ok),
        .data_req   (data_req),
        .data_wen   (data_wen),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_ok    (data_ok),
        .mem_req    (mem_req),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok),
        .mem_rdata  (mem_rdata),
        .cpu_stall  (cpu_stall),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        instReq;
        logic [31:0] instAddr;
        logic        dataReq;
        logic [3:0]  dataWen;
        logic [31:0] dataAddr;
        logic [31:0] dataWdata;
        logic [31:0] memRdata;
        logic        expData;
        logic [3:0]  expWen;
        logic [31:0] expAddr;
        logic [31:0] expWdata;
        logic [31:0] expInstRdata;
        logic [31:0] expDataRdata;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        inst_req    = v.instReq;
        inst_addr   = v.instAddr;
        data_req    = v.dataReq;
        data_wen    = v.dataWen;
        data_addr   = v.dataAddr;
        data_wdata  = v.dataWdata;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
    endtask

    // Zero-wait memory: address accepted in the first ADDR cycle, data in the first DATA cycle.
    task automatic runVector(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        applyStimulus(v);
        #1;
        checkOutput({tag, "_stall_req"}, 32'(cpu_stall), 32'(v.instReq | v.dataReq));
        @(negedge clk);
        checkOutput({tag, "_mem_req"}, 32'(mem_req), 32'd1);
        checkOutput({tag, "_mem_addr"}, mem_addr, v.expAddr);
        checkOutput({tag, "_mem_wen"}, 32'(mem_wen), 32'(v.expWen));
        checkOutput({tag, "_mem_wdata"}, mem_wdata, v.expWdata);
        checkOutput({tag, "_early_ok"}, 32'(inst_ok | data_ok), 32'd0);
        mem_addr_ok = 1'b1;
        @(negedge clk);
        mem_addr_ok = 1'b0;
        checkOutput({tag, "_req_drop"}, 32'(mem_req), 32'd0);
        mem_data_ok = 1'b1;
        mem_rdata   = v.memRdata;
        @(negedge clk);
        mem_data_ok = 1'b0;
        checkOutput({tag, "_inst_ok"}, 32'(inst_ok), 32'(!v.expData));
        checkOutput({tag, "_data_ok"}, 32'(data_ok), 32'(v.expData));
        checkOutput({tag, "_bus_err"}, 32'(bus_err), 32'd0);
        checkOutput({tag, "_inst_rdata"}, inst_rdata, v.expInstRdata);
        checkOutput({tag, "_data_rdata"}, data_rdata, v.expDataRdata);
        checkOutput({tag, "_stall_ok"}, 32'(cpu_stall), 32'(v.expData ? v.instReq : v.dataReq));
        if (v.expData) data_req = 1'b0;
        else inst_req = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_ok_pulse"}, 32'(inst_ok | data_ok), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0] pattern;
        logic       sawOk;
        int         waitCount;

        vecs[0] = '{1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0, 32'h3C080001,
                    1'b0, 4'h0, 32'hBFC00000, 32'h0, 32'h3C080001, 32'h0};
        vecs[1] = '{1'b1, 32'hBFC00004, 1'b1, 4'hF, 32'h80000010, 32'hDEADBEEF, 32'h11111111,
                    1'b1, 4'hF, 32'h80000010, 32'hDEADBEEF, 32'h3C080001, 32'h0};
        vecs[2] = '{1'b1, 32'hBFC00004, 1'b0, 4'h0, 32'h0, 32'h0, 32'h24090002,
                    1'b0, 4'h0, 32'hBFC00004, 32'h0, 32'h24090002, 32'h0};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 4'h0, 32'h80000020, 32'h12345678, 32'hCAFEF00D,
                    1'b1, 4'h0, 32'h80000020, 32'h12345678, 32'h24090002, 32'hCAFEF00D};
        vecs[4] = '{1'b0, 32'h0, 1'b1, 4'h3, 32'h80000030, 32'h0000ABCD, 32'h99999999,
                    1'b1, 4'h3, 32'h80000030, 32'h0000ABCD, 32'h24090002, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 32'hBFC00008, 1'b0, 4'hF, 32'h80000070, 32'hFFFFFFFF, 32'h8C020000,
                    1'b0, 4'h0, 32'hBFC00008, 32'h0, 32'h8C020000, 32'hCAFEF00D};

        rst = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h0;
        data_req = 1'b0; data_wen = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;

        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_ok", 32'(inst_ok | data_ok | bus_err), 32'd0);
        checkOutput("rst_rdata", inst_rdata | data_rdata, 32'd0);
        checkOutput("rst_stall", 32'(cpu_stall), 32'd1);
        inst_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("idle_mem_req", 32'(mem_req), 32'd0);

        $display("[TB] vector table");
        for (int i = 0; i < 6; i++) runVector(i, vecs[i]);

        $display("[TB] starvation");
        pattern   = 10'b0111101111;
        inst_req  = 1'b1; inst_addr = 32'hBFC00010;
        data_req  = 1'b1; data_wen = 4'hF; data_addr = 32'h80000040; data_wdata = 32'h1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("starve%0d_req", i), 32'(mem_req), 32'd1);
            checkOutput($sformatf("starve%0d_addr", i), mem_addr,
                        pattern[i] ? 32'h80000040 : 32'hBFC00010);
            mem_addr_ok = 1'b1;
            @(negedge clk);
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b1;
            mem_rdata   = 32'hA0A0A0A0;
            @(negedge clk);
            mem_data_ok = 1'b0;
            checkOutput($sformatf("starve%0d_data_ok", i), 32'(data_ok), 32'(pattern[i]));
            checkOutput($sformatf("starve%0d_inst_ok", i), 32'(inst_ok), 32'(!pattern[i]));
            @(negedge clk);
        end
        inst_req = 1'b0;
        data_req = 1'b0;
        @(negedge clk);

        $display("[TB] request dropped mid-transaction");
        inst_req = 1'b1; inst_addr = 32'hBFC00020;
        @(negedge clk);
        inst_req = 1'b0;
        #1;
        checkOutput("drop_stall", 32'(cpu_stall), 32'd0);
        mem_addr_ok = 1'b1;
        @(negedge clk);
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h0BADF00D;
        @(negedge clk);
        mem_data_ok = 1'b0;
        checkOutput("drop_inst_ok", 32'(inst_ok), 32'd1);
        checkOutput("drop_inst_rdata", inst_rdata, 32'h0BADF00D);
        @(negedge clk);
        checkOutput("drop_ok_end", 32'(inst_ok), 32'd0);

        $display("[TB] acknowledges in the wrong state");
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        @(negedge clk);
        checkOutput("idle_ack_req", 32'(mem_req), 32'd0);
        checkOutput("idle_ack_ok", 32'(inst_ok | data_ok), 32'd0);
        data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h80000050; data_wdata = 32'h0;
        mem_addr_ok = 1'b0;
        @(negedge clk);
        checkOutput("ws_grant", 32'(mem_req), 32'd1);
        @(negedge clk);
        checkOutput("ws_addr_hold", 32'(mem_req), 32'd1);
        checkOutput("ws_addr_ok", 32'(data_ok), 32'd0);
        mem_data_ok = 1'b0;
        mem_addr_ok = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("ws_data_hold", 32'(data_ok), 32'd0);
        checkOutput("ws_data_req", 32'(mem_req), 32'd0);
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h55AA55AA;
        @(negedge clk);
        mem_data_ok = 1'b0;
        checkOutput("ws_data_ok", 32'(data_ok), 32'd1);
        checkOutput("ws_data_rdata", data_rdata, 32'h55AA55AA);
        data_req = 1'b0;
        @(negedge clk);

        $display("[TB] reset during DATA");
        inst_req = 1'b1; inst_addr = 32'hBFC00030;
        @(negedge clk);
        mem_addr_ok = 1'b1;
        @(negedge clk);
        mem_addr_ok = 1'b0;
        rst = 1'b0;
        inst_req = 1'b0;
        #1;
        checkOutput("mid_rst_mem", 32'(mem_req) | 32'(mem_wen) | mem_addr | mem_wdata, 32'd0);
        checkOutput("mid_rst_rdata", inst_rdata | data_rdata, 32'd0);
        checkOutput("mid_rst_ok", 32'(inst_ok | data_ok | bus_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h77777777;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_data_ok = 1'b0;
            checkOutput($sformatf("post_rst%0d_ok", i), 32'(inst_ok | data_ok), 32'd0);
            checkOutput($sformatf("post_rst%0d_req", i), 32'(mem_req), 32'd0);
            checkOutput($sformatf("post_rst%0d_rdata", i), inst_rdata, 32'd0);
        end
        inst_req = 1'b1; inst_addr = 32'hBFC00040;
        @(negedge clk);
        checkOutput("first_grant_req", 32'(mem_req), 32'd1);
        checkOutput("first_grant_addr", mem_addr, 32'hBFC00040);
        mem_addr_ok = 1'b1;
        @(negedge clk);
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h00000002;
        @(negedge clk);
        mem_data_ok = 1'b0;
        checkOutput("first_grant_ok", 32'(inst_ok), 32'd1);
        inst_req = 1'b0;
        @(negedge clk);

        $display("[TB] stuck address phase");
        data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h80000060;
`ifdef ARB_TIMEOUT_EN
        waitCount = 0;
        sawOk = 1'b0;
        while (!sawOk && waitCount < 300) begin
            @(negedge clk);
            waitCount++;
            sawOk = data_ok;
        end
        checkOutput("timeout_cycles", 32'(waitCount), 32'd257);
        checkOutput("timeout_bus_err", 32'(bus_err), 32'd1);
        checkOutput("timeout_rdata", data_rdata, 32'd0);
        data_req = 1'b0;
        @(negedge clk);
        checkOutput("timeout_err_pulse", 32'(bus_err | data_ok), 32'd0);
`else
        sawOk = 1'b0;
        waitCount = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (data_ok || inst_ok || bus_err) sawOk = 1'b1;
            waitCount++;
        end
        checkOutput("no_timeout_ok", 32'(sawOk), 32'd0);
        checkOutput("no_timeout_req", 32'(mem_req), 32'd1);
        checkOutput("no_timeout_cycles", 32'(waitCount), 32'd1000);
        data_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("no_timeout_recover", 32'(mem_req), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
